// File: rtl/snn_pkg.sv
// Shared definitions for the SNN classifier sequencer: network sizes,
// address widths, the sequencer state encoding and the activation-LUT
// index mapping with its saturation bounds.
package snn_pkg;

    localparam int N_IN        = 784;
    localparam int N_HID       = 32;
    localparam int N_OUT       = 10;
    localparam int ROM_LAT_DEF = 1;

    localparam int ACC_W  = 26;
    localparam int Q_W    = 8;
    localparam int IN_AW  = 10;
    localparam int HW_AW  = 15;
    localparam int OW_AW  = 9;
    localparam int HID_AW = 5;
    localparam int OUT_AW = 4;
    localparam int LUT_AW = 11;

    localparam logic [LUT_AW-1:0] LUT_OFFSET = 11'h400;
    localparam logic [LUT_AW-1:0] SAT_POS    = 11'h3FF;
    localparam logic [LUT_AW-1:0] SAT_NEG    = 11'h400;

    localparam logic PH_HID = 1'b0;
    localparam logic PH_OUT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_DRAIN,
        S_LUT,
        S_WB,
        S_MAX,
        S_FIN
    } state_t;

    // Clamp acc[25:7] into the signed 11-bit LUT window, then move the
    // window origin to the middle of the table (bit 10 inverted).
    function automatic logic [LUT_AW-1:0] lut_index(input logic       sign,
                                                   input logic [7:0] hi,
                                                   input logic [LUT_AW-1:0] mid);
        logic [LUT_AW-1:0] s;
        if (!sign && (hi != 8'h00))
            s = SAT_POS;
        else if (sign && (hi != 8'hFF))
            s = SAT_NEG;
        else
            s = mid;
        return s ^ LUT_OFFSET;
    endfunction

endpackage

// File: rtl/snn_argmax.sv
// Running argmax over the output-unit RAM read stream. Issued indices are
// delayed by the RAM latency so each read value lines up with its index;
// the first entry seeds the best value and later entries replace it only
// when strictly greater, so ties keep the lowest index.
module snn_argmax
    import snn_pkg::*;
#(
    parameter int LAT = ROM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [OUT_AW-1:0] in_idx,
    input  logic [Q_W-1:0]    q,
    output logic [OUT_AW-1:0] res_idx
);

    logic [LAT-1:0]             vld_sr;
    logic [LAT-1:0][OUT_AW-1:0] idx_sr;
    logic [Q_W-1:0]             best_val;
    logic [OUT_AW-1:0]          best_idx;
    logic [OUT_AW-1:0]          cur_idx;
    logic                       take;

    assign cur_idx = idx_sr[LAT-1];
    assign take    = vld_sr[LAT-1] && ((cur_idx == '0) || (q > best_val));
    // Includes the compare happening this cycle so the caller can latch
    // the final winner on the same edge as the last compare.
    assign res_idx = take ? cur_idx : best_idx;

    // Align issued index/valid with the RAM read latency, track the best.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr   <= '0;
            idx_sr   <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else begin
            vld_sr[0] <= in_vld;
            idx_sr[0] <= in_idx;
            for (int j = 1; j < LAT; j++) begin
                vld_sr[j] <= vld_sr[j-1];
                idx_sr[j] <= idx_sr[j-1];
            end
            if (take) begin
                best_val <= q;
                best_idx <= cur_idx;
            end
        end
    end

endmodule

// File: rtl/snn_seq.sv
// Control sequencer for the 784-32-10 SNN classifier datapath: drives all
// ROM/RAM addresses, MAC clear/enable, operand select, activation-LUT
// address and RAM write strobes, then runs an argmax over the outputs.
// Optional build macro SNN_SEQ_PERF_EN adds the busy_cycles counter port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// CLR     | clear MAC, present index 0 addresses
// ACC     | present one operand index per cycle
// DRAIN   | MAC still accumulating the last ROM_LAT operands
// LUT     | drive saturated activation-LUT address from acc
// WB      | write LUT result into hidden/output RAM, advance neuron
// MAX     | stream output RAM through the argmax
// FIN     | done pulse, digit valid
module snn_seq
    import snn_pkg::*;
#(
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ACC_W-1:0]  acc,
    input  logic [Q_W-1:0]    lut_q,
    input  logic [Q_W-1:0]    out_q,
    output logic [IN_AW-1:0]  addr_input_unit,
    output logic [HW_AW-1:0]  hidden_weight_addr,
    output logic [OW_AW-1:0]  output_weight_addr,
    output logic [HID_AW-1:0] hid_addr,
    output logic              hid_we,
    output logic [OUT_AW-1:0] out_addr,
    output logic              out_we,
    output logic [LUT_AW-1:0] lut_addr,
    output logic              mac_clr_n,
    output logic              mac_en,
    output logic              sel_hidden,
    output logic              done,
    output logic [3:0]        digit
`ifdef SNN_SEQ_PERF_EN
    ,
    output logic [31:0]       busy_cycles
`endif
);

    localparam int LC_W = $clog2(ROM_LAT + 1);
    localparam int MC_W = $clog2(N_OUT + ROM_LAT);
    localparam logic [LC_W-1:0] DRAIN_LAST = LC_W'(ROM_LAT - 1);
    localparam logic [MC_W-1:0] MAX_LAST   = MC_W'(N_OUT + ROM_LAT - 1);
    localparam logic [MC_W-1:0] MAX_ISSUE  = MC_W'(N_OUT);

    state_t              state, state_nxt;
    logic                phase;
    logic [HID_AW-1:0]   k;
    logic [IN_AW-1:0]    i;
    logic [HW_AW-1:0]    hw_cnt;
    logic [OW_AW-1:0]    ow_cnt;
    logic [LC_W-1:0]     lat_cnt;
    logic [MC_W-1:0]     max_cnt;
    logic [ROM_LAT-1:0]  en_sr;
    logic [3:0]          digit_q;
    logic [OUT_AW-1:0]   res_idx;
    logic                i_last, k_last, drain_last, max_last, max_issue;
    logic                unused_bits;

    // The LUT output goes straight to the RAMs; acc[6:0] lies below the LUT window.
    assign unused_bits = ^{lut_q, acc[6:0]};

    assign i_last     = (phase == PH_OUT) ? (i == IN_AW'(N_HID - 1)) : (i == IN_AW'(N_IN - 1));
    assign k_last     = (phase == PH_OUT) ? (k == HID_AW'(N_OUT - 1)) : (k == HID_AW'(N_HID - 1));
    assign drain_last = (lat_cnt == DRAIN_LAST);
    assign max_last   = (max_cnt == MAX_LAST);
    assign max_issue  = (state == S_MAX) && (max_cnt < MAX_ISSUE);

    assign hidden_weight_addr = hw_cnt;
    assign output_weight_addr = ow_cnt;
    assign mac_en             = en_sr[ROM_LAT-1];
    assign sel_hidden         = (phase == PH_OUT);
    assign digit              = digit_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and strobes/addresses decoded from the current state.
    always_comb begin
        state_nxt       = state;
        mac_clr_n       = 1'b1;
        hid_we          = 1'b0;
        out_we          = 1'b0;
        done            = 1'b0;
        addr_input_unit = '0;
        hid_addr        = '0;
        out_addr        = '0;
        lut_addr        = '0;
        if (phase == PH_HID) addr_input_unit = i;
        else                 hid_addr        = i[HID_AW-1:0];
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_CLR;
            S_CLR: begin
                mac_clr_n = 1'b0;
                state_nxt = S_ACC;
            end
            S_ACC:   if (i_last) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_last) state_nxt = S_LUT;
            S_LUT: begin
                lut_addr  = lut_index(acc[25], acc[24:17], acc[17:7]);
                state_nxt = S_WB;
            end
            S_WB: begin
                if (phase == PH_HID) begin
                    hid_we   = 1'b1;
                    hid_addr = k;
                end else begin
                    out_we   = 1'b1;
                    out_addr = OUT_AW'(k);
                end
                state_nxt = ((phase == PH_OUT) && k_last) ? S_MAX : S_CLR;
            end
            S_MAX: begin
                if (max_issue) out_addr = OUT_AW'(max_cnt);
                if (max_last)  state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Index, neuron and running weight-address counters; weight counters
    // step to the next neuron's base at WB rather than past the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= PH_HID;
            k      <= '0;
            i      <= '0;
            hw_cnt <= '0;
            ow_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    phase  <= PH_HID;
                    k      <= '0;
                    i      <= '0;
                    hw_cnt <= '0;
                    ow_cnt <= '0;
                end
                S_ACC: if (!i_last) begin
                    i <= i + 1'b1;
                    if (phase == PH_OUT) ow_cnt <= ow_cnt + 1'b1;
                    else                 hw_cnt <= hw_cnt + 1'b1;
                end
                S_WB: begin
                    i <= '0;
                    if (phase == PH_HID) begin
                        if (k_last) begin
                            phase <= PH_OUT;
                            k     <= '0;
                        end else begin
                            k      <= k + 1'b1;
                            hw_cnt <= hw_cnt + 1'b1;
                        end
                    end else if (!k_last) begin
                        k      <= k + 1'b1;
                        ow_cnt <= ow_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    phase  <= PH_HID;
                    k      <= '0;
                    i      <= '0;
                    hw_cnt <= '0;
                    ow_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Drain/max timers, MAC enable delay line and the latched result digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
            max_cnt <= '0;
            en_sr   <= '0;
            digit_q <= '0;
        end else begin
            lat_cnt  <= (state == S_DRAIN) ? lat_cnt + 1'b1 : '0;
            max_cnt  <= (state == S_MAX) ? max_cnt + 1'b1 : '0;
            en_sr[0] <= (state == S_ACC);
            for (int j = 1; j < ROM_LAT; j++) en_sr[j] <= en_sr[j-1];
            if ((state == S_MAX) && max_last) digit_q <= res_idx;
        end
    end

    snn_argmax #(
        .LAT (ROM_LAT)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (max_issue),
        .in_idx  (OUT_AW'(max_cnt)),
        .q       (out_q),
        .res_idx (res_idx)
    );

`ifdef SNN_SEQ_PERF_EN
    // Busy-cycle counter: cleared by an accepted start, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_cycles <= '0;
        else if ((state == S_IDLE) && start)
            busy_cycles <= '0;
        else if ((state != S_IDLE) && (busy_cycles != '1))
            busy_cycles <= busy_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_snn_seq.sv
// Directed bench for snn_seq. Cycle numbering: cycle 0 is the cycle in which
// start is high while IDLE; the sampling edge begins cycle 1 (CLR).
// Neuron k of the hidden phase: CLR 788k+1, ACC 788k+2..788k+785,
// DRAIN +786, LUT +787, WB +788. Output phase starts at 25217 (36/neuron),
// MAX 25577..25587, FIN 25588.
module tb_snn_seq;

    logic        clk, rst_n, start;
    logic [25:0] acc;
    logic [7:0]  lut_q, out_q;
    logic [9:0]  addr_input_unit;
    logic [14:0] hidden_weight_addr;
    logic [8:0]  output_weight_addr;
    logic [4:0]  hid_addr;
    logic        hid_we;
    logic [3:0]  out_addr;
    logic        out_we;
    logic [10:0] lut_addr;
    logic        mac_clr_n, mac_en, sel_hidden, done;
    logic [3:0]  digit;
`ifdef SNN_SEQ_PERF_EN
    logic [31:0] busy_cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;
    int done_cnt, hid_wb, out_wb;
    logic [7:0] out_tbl [10];

    snn_seq dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .acc                (acc),
        .lut_q              (lut_q),
        .out_q              (out_q),
        .addr_input_unit    (addr_input_unit),
        .hidden_weight_addr (hidden_weight_addr),
        .output_weight_addr (output_weight_addr),
        .hid_addr           (hid_addr),
        .hid_we             (hid_we),
        .out_addr           (out_addr),
        .out_we             (out_we),
        .lut_addr           (lut_addr),
        .mac_clr_n          (mac_clr_n),
        .mac_en             (mac_en),
        .sel_hidden         (sel_hidden),
        .done               (done),
        .digit              (digit)
`ifdef SNN_SEQ_PERF_EN
        ,
        .busy_cycles        (busy_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; output RAM model returns the entry addressed last cycle.
    task automatic tick();
        logic [3:0] a;
        a = out_addr;
        @(posedge clk);
        #1;
        out_q = (a < 4'd10) ? out_tbl[a] : 8'h00;
        n++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        n = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_strobes"}, {26'd0, mac_clr_n, done, mac_en, hid_we, out_we, sel_hidden}, 32'b100000);
        chk({pfx, "_in_hw_addr"}, {7'd0, addr_input_unit, hidden_weight_addr}, 32'd0);
        chk({pfx, "_ow_hid_out_lut"}, {3'd0, output_weight_addr, hid_addr, out_addr, lut_addr}, 32'd0);
        chk({pfx, "_digit"}, digit, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        acc   = '0;
        lut_q = '0;
        out_q = '0;
        out_tbl = '{default: 8'd0};
        repeat (3) tick();
        chk_reset("por");
        rst_n = 1'b1;
        repeat (2) tick();
        chk_reset("idle");

        // Aborted run: reset in the middle of the first hidden neuron.
        pulse_start();
        while (n < 500) tick();
        chk("abort_hw_addr", hidden_weight_addr, 32'd498);
        chk("abort_mac_en", mac_en, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("midacc");
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset("post_abort");

        // Run A: tie between entries 1 and 2, plus address/saturation trace.
        out_tbl = '{8'd5, 8'd9, 8'd9, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        done_cnt = 0;
        hid_wb   = 0;
        out_wb   = 0;
        pulse_start();
        while (n <= 25595) begin
            if (n == 1) chk("a_clr_low", mac_clr_n, 32'd0);
            if (n == 2) chk("a_clr_high", mac_clr_n, 32'd1);
            if (n == 2) chk("a_en_first_acc", mac_en, 32'd0);
            if (n == 3) chk("a_en_second_acc", mac_en, 32'd1);
            if (n == 786) chk("a_en_drain", mac_en, 32'd1);
            if (n == 787) chk("a_en_lut", mac_en, 32'd0);
            if (n >= 2 && n <= 785) begin
                chk("a_hw_k0", hidden_weight_addr, n - 2);
                chk("a_in_k0", addr_input_unit, n - 2);
            end
            if (n >= 790 && n <= 1573) chk("a_hw_k1", hidden_weight_addr, 784 + n - 790);
            if (n == 787)  chk("a_lut_sat_pos", lut_addr, 32'h7FF);
            if (n == 788)  chk("a_lut_idle_wb", lut_addr, 32'h000);
            if (n == 1575) chk("a_lut_sat_neg", lut_addr, 32'h000);
            if (n == 2363) chk("a_lut_small", lut_addr, 32'h401);
            if (n == 25216) chk("a_sel_hid", sel_hidden, 32'd0);
            if (n == 25217) chk("a_sel_out", sel_hidden, 32'd1);
            if (n == 25573) chk("a_ow_last", output_weight_addr, 32'd319);
`ifdef SNN_SEQ_PERF_EN
            if (n == 1) chk("a_busy_first", busy_cycles, 32'd0);
            if (n == 2) chk("a_busy_second", busy_cycles, 32'd1);
`endif
            if (hid_we) begin
                chk("a_hid_addr", hid_addr, hid_wb);
                chk("a_hid_we_cycle", n, 788 * hid_wb + 788);
                hid_wb++;
            end
            if (out_we) begin
                chk("a_out_addr", out_addr, out_wb);
                chk("a_out_we_cycle", n, 25252 + 36 * out_wb);
                out_wb++;
            end
            if (done) begin
                done_cnt++;
                chk("a_done_cycle", n, 32'd25588);
                chk("a_digit_tie", digit, 32'd1);
                chk("a_hw_final", hidden_weight_addr, 32'd25087);
                chk("a_ow_final", output_weight_addr, 32'd319);
            end
            start = (n + 1 == 1000) || (n + 1 == 1001) || (n + 1 == 20000);
            case (n + 1)
                787:     acc = 26'h0100000;
                1575:    acc = 26'h3F00000;
                2363:    acc = 26'h0000080;
                default: acc = 26'h0000000;
            endcase
            tick();
        end
        start = 1'b0;
        chk("a_done_count", done_cnt, 32'd1);
        chk("a_hid_we_count", hid_wb, 32'd32);
        chk("a_out_we_count", out_wb, 32'd10);
        chk("a_idle_hw", hidden_weight_addr, 32'd0);
        chk("a_idle_ow", output_weight_addr, 32'd0);
        chk("a_idle_sel", sel_hidden, 32'd0);
        chk("a_digit_held", digit, 32'd1);
`ifdef SNN_SEQ_PERF_EN
        chk("a_busy_total", busy_cycles, 32'd25588);
`endif

        // Run B: all-zero outputs select index 0; previous digit held meanwhile.
        out_tbl = '{default: 8'd0};
        pulse_start();
`ifdef SNN_SEQ_PERF_EN
        chk("b_busy_restart", busy_cycles, 32'd0);
`endif
        while (!done && n < 26000) begin
            if (n == 1 || n >= 25570) chk("b_digit_hold", digit, 32'd1);
            tick();
        end
        chk("b_done_cycle", n, 32'd25588);
        chk("b_digit_zero", digit, 32'd0);
        tick();
        chk("b_done_single", done, 32'd0);
`ifdef SNN_SEQ_PERF_EN
        chk("b_busy_total", busy_cycles, 32'd25588);
`endif

        // Run C: only the last entry is strictly greater.
        out_tbl = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
        pulse_start();
        while (!done && n < 26000) begin
            if (n >= 25570) chk("c_digit_hold", digit, 32'd0);
            tick();
        end
        chk("c_done_cycle", n, 32'd25588);
        chk("c_digit_nine", digit, 32'd9);
        repeat (3) tick();
        chk("c_digit_held", digit, 32'd9);
        chk("c_done_low", done, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snn_seq.md
Name: snn_seq

Overview:
- Control sequencer for the SNN digit-classifier datapath: the 784-input / 32-hidden / 10-output MAC pipeline.
- Generates every memory address, the MAC clear/enable strobes, the operand select, the activation-LUT address (with saturation) and the RAM write strobes.
- Runs a final argmax over the output units.
- Contains no memories or multipliers; sits between the top-level start/done handshake and the ROM/RAM/MAC instances.

Parameters:
- N_IN, 784, input units per image
- N_HID, 32, hidden units
- N_OUT, 10, output units
- ROM_LAT, 1, read latency of every ROM/RAM in cycles; the MAC enable and the write-back are delayed by this amount

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous active-low
- start  in  1  begin classification; sampled only in IDLE
- acc  in  26  signed MAC accumulator
- lut_q  in  8  activation LUT output (unsigned)
- out_q  in  8  output-unit RAM read data (unsigned)
- addr_input_unit  out  10  input-bit RAM address
- hidden_weight_addr  out  15  hidden weight ROM address
- output_weight_addr  out  9  output weight ROM address
- hid_addr  out  5  hidden-unit RAM address (write and read)
- hid_we  out  1  hidden-unit RAM write strobe
- out_addr  out  4  output-unit RAM address (write and read)
- out_we  out  1  output-unit RAM write strobe
- lut_addr  out  11  activation LUT address
- mac_clr_n  out  1  synchronous MAC clear, active-low
- mac_en  out  1  MAC accumulate enable
- sel_hidden  out  1  operand-a select: 0 = extended input bit, 1 = hidden RAM data
- done  out  1  one-cycle completion pulse
- digit  out  4  classified digit; held until next start

Behaviour:
- Reset: all outputs 0 except mac_clr_n = 1; state IDLE; all counters 0. Reset mid-operation aborts and returns to IDLE; no partial digit is kept.
- States: IDLE, CLR, ACC, DRAIN, LUT, WB, MAX, FIN. A phase flag (HID/OUT) is reused across CLR..WB. sel_hidden = 1 while the phase is OUT.
- IDLE: on start go to CLR with phase = HID and neuron k = 0. start is ignored in all other states.
- CLR (1 cycle): mac_clr_n = 0; present index i = 0 addresses.
- ACC (N_IN cycles in HID, N_HID cycles in OUT): present index i each cycle.
  - HID addresses: addr_input_unit = i, hidden_weight_addr = k*N_IN + i.
  - OUT addresses: hid_addr = i, output_weight_addr = k*N_HID + i.
  - All weight addresses come from a running counter, not a multiplier; the counter is never reset between neurons.
  - mac_en is the "address valid" flag delayed ROM_LAT cycles.
- DRAIN (ROM_LAT cycles): mac_en continues for the last operands; no new addresses.
- LUT (1 cycle): drive lut_addr from acc.
  - Saturated value s: s = 0x3FF if acc[25] = 0 and acc[24:17] != 0; s = 0x400 if acc[25] = 1 and acc[24:17] != all-ones; otherwise s = acc[17:7].
  - lut_addr = s + 0x400 (mod 2048), i.e. s with bit 10 inverted.
- WB (1 cycle): lut_q is valid.
  - Phase HID: hid_we = 1, hid_addr = k.
  - Phase OUT: out_we = 1, out_addr = k.
  - Then k++.
  - If phase HID and k == N_HID-1 at WB: set phase = OUT, k = 0, go to CLR.
  - If phase OUT and k == N_OUT-1 at WB: go to MAX. Otherwise go to CLR.
- MAX (N_OUT + ROM_LAT cycles): out_addr = 0..N_OUT-1 over consecutive cycles.
  - out_q is compared ROM_LAT cycles later; unsigned compare.
  - Best is updated only on strictly greater, so ties resolve to the lowest index.
  - The best value is initialised from entry 0.
- FIN (1 cycle): done = 1, digit = best index; go to IDLE.
- Latency at defaults: start sampled at cycle 0 gives done high at cycle 25588.
  - Hidden phase: 32 x 788 cycles.
  - Output phase: 10 x 36 cycles.
  - MAX: 11 cycles.
  - FIN: 1 cycle.
- Counter wrap: hidden_weight_addr max value = 25087; output_weight_addr max value = 319. Neither wraps during a run. Both return to 0 on entering IDLE.

Optional Feature:
- Macro: SNN_SEQ_PERF_EN.
- Defined: adds output port busy_cycles [31:0]. It clears on start, increments every non-IDLE cycle, saturates at all-ones, and holds its value in IDLE (25588 after a default run).
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum;
  - constants N_IN / N_HID / N_OUT and the address widths;
  - the LUT offset 0x400 and the saturation bounds.
- One sub-module: snn_argmax. It holds the running max, index, valid pipeline and the strict-greater compare, and is instantiated once in MAX.

Test Plan:
- Reset mid-ACC (assert rst_n low at cycle 500) -> all outputs at reset values immediately; the next start runs a full classification with correct done timing (25588).
- Handshake check: start pulsed at cycle 0 -> exactly one done pulse at cycle 25588; start toggled during busy is ignored; digit is stable until the next start.
- Address trace: check hidden_weight_addr sequence 0..783 for k = 0 and 784..1567 for k = 1; hid_we pulses with hid_addr = 0..31; output_weight_addr ends at 319.
- Saturation: acc = 0x0100000 -> lut_addr 0x7FF; acc = 0x3F00000 (negative, out of range) -> lut_addr 0x000; acc = 0x0000080 -> lut_addr 0x401.
- Argmax: out_q model values {5,9,9,3,0,0,0,0,0,1} -> digit 1 (tie resolves to lower index); all zeros -> digit 0; max at index 9 -> digit 9.
- With SNN_SEQ_PERF_EN defined -> busy_cycles = 25588 after done; second run restarts the count from 0.
